// File: rtl/udp_transmit_framer_if.sv
// Framer bus: 9-bit input byte stream, committed header plus transmit handshake, payload stream, status.
// The master modport is the framer side; the slave modport is the surrounding logic.
interface udp_transmit_framer_if #(
  parameter int COUNTER_WIDTH = 16
);
  logic [8:0]               data;
  logic                     data_valid;
  logic                     data_ready;
  logic [47:0]              mac_destination;
  logic [31:0]              ipv4_destination;
  logic [15:0]              udp_destination;
  logic [15:0]              udp_source;
  logic [15:0]              udp_data_size;
  logic                     transmit_valid;
  logic                     transmit_ready;
  logic [7:0]               udp_data;
  logic                     udp_data_valid;
  logic                     udp_data_last;
  logic                     udp_data_ready;
  logic                     frame_error;
  logic [2:0]               error_code;
  logic [COUNTER_WIDTH-1:0] frame_count;
  logic [COUNTER_WIDTH-1:0] error_count;

  modport master (
    input  data, data_valid, transmit_ready, udp_data_ready,
    output data_ready, mac_destination, ipv4_destination, udp_destination, udp_source,
           udp_data_size, transmit_valid, udp_data, udp_data_valid, udp_data_last,
           frame_error, error_code, frame_count, error_count
  );

  modport slave (
    output data, data_valid, transmit_ready, udp_data_ready,
    input  data_ready, mac_destination, ipv4_destination, udp_destination, udp_source,
           udp_data_size, transmit_valid, udp_data, udp_data_valid, udp_data_last,
           frame_error, error_code, frame_count, error_count
  );
endinterface

// File: rtl/udp_transmit_framer.sv
// UDP transmit framer: parses a 16-byte header from a start-marked byte stream, requests the transmitter, forwards payload.
// Payload latency 1 cycle at 1 byte/cycle; input stalls while requesting or while the output register is full and not draining.
module udp_transmit_framer #(
  parameter int MAX_UDP_DATA_SIZE = 1472,
  parameter int GRANT_TIMEOUT     = 65535,
  parameter int COUNTER_WIDTH     = 16
) (
  input logic clock,
  input logic reset,
  udp_transmit_framer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_REQUEST,
    S_PAYLOAD,
    S_DISCARD
  } state_t;

  typedef struct packed {
    logic [47:0] mac_destination;
    logic [31:0] ipv4_destination;
    logic [15:0] udp_destination;
    logic [15:0] udp_source;
    logic [15:0] udp_data_size;
  } hdr_t;

  localparam logic [2:0] ERR_RESYNC   = 3'd1;
  localparam logic [2:0] ERR_SIZE     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
  localparam logic [2:0] ERR_TRUNC    = 3'd4;
  localparam logic [15:0] MAX_SIZE    = 16'(MAX_UDP_DATA_SIZE);
  localparam int WAIT_W               = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((GRANT_TIMEOUT > 0) ? GRANT_TIMEOUT - 1 : 0);

  state_t                   state;
  state_t                   state_nxt;
  logic [15:0][7:0]         shadow;
  logic [3:0]               index;
  hdr_t                     hdr_q;
  hdr_t                     hdr_in;
  logic [15:0]              remaining;
  logic [WAIT_W-1:0]        wait_count;
  logic                     tx_valid_q;
  logic [7:0]               out_dat;
  logic                     out_vld;
  logic                     out_last;
  logic                     err_q;
  logic [2:0]               err_code_q;
  logic [COUNTER_WIDTH-1:0] frame_cnt;
  logic [COUNTER_WIDTH-1:0] err_cnt;

  logic                     ready;
  logic                     accept;
  logic                     sof;
  logic [7:0]               byte_in;
  logic [15:0]              size_in;

  logic                     hdr_restart;
  logic                     hdr_wr;
  logic                     commit;
  logic                     pay_load;
  logic                     frame_done;
  logic                     grant;
  logic                     expire;
  logic                     err_set;
  logic [2:0]               err_code_nxt;

  assign sof     = bus.data[8];
  assign byte_in = bus.data[7:0];
  // Size is judged on the final header byte as it arrives, before it reaches the shadow.
  assign size_in = {shadow[14], byte_in};
  assign hdr_in  = {shadow[0], shadow[1], shadow[2], shadow[3], shadow[4], shadow[5],
                    shadow[6], shadow[7], shadow[8], shadow[9],
                    shadow[10], shadow[11], shadow[12], shadow[13], size_in};

  always_comb begin
    ready = 1'b0;
    case (state)
      S_IDLE, S_HEADER, S_DISCARD: ready = 1'b1;
      S_PAYLOAD:                   ready = !out_vld || bus.udp_data_ready;
      default:                     ready = 1'b0;
    endcase
  end

  assign bus.data_ready = ready && !reset;
  assign accept         = bus.data_valid && bus.data_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hdr_restart  = 1'b0;
    hdr_wr       = 1'b0;
    commit       = 1'b0;
    pay_load     = 1'b0;
    frame_done   = 1'b0;
    grant        = 1'b0;
    expire       = 1'b0;
    err_set      = 1'b0;
    err_code_nxt = 3'd0;
    case (state)
      S_IDLE: begin
        if (accept && sof) begin
          hdr_restart = 1'b1;
          state_nxt   = S_HEADER;
        end
      end
      S_HEADER: begin
        if (accept) begin
          if (sof) begin
            hdr_restart  = 1'b1;
            err_set      = 1'b1;
            err_code_nxt = ERR_RESYNC;
          end else if (index == 4'd15) begin
            if (size_in == 16'd0 || size_in > MAX_SIZE) begin
              err_set      = 1'b1;
              err_code_nxt = ERR_SIZE;
              state_nxt    = S_DISCARD;
            end else begin
              commit    = 1'b1;
              state_nxt = S_REQUEST;
            end
          end else begin
            hdr_wr = 1'b1;
          end
        end
      end
      S_REQUEST: begin
        // A grant arriving in the expiry cycle takes priority over the timeout.
        if (bus.transmit_ready) begin
          grant     = 1'b1;
          state_nxt = S_PAYLOAD;
        end else if (GRANT_TIMEOUT != 0 && wait_count == WAIT_LAST) begin
          expire       = 1'b1;
          err_set      = 1'b1;
          err_code_nxt = ERR_TIMEOUT;
          state_nxt    = S_DISCARD;
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          if (sof) begin
            hdr_restart  = 1'b1;
            err_set      = 1'b1;
            err_code_nxt = ERR_TRUNC;
            state_nxt    = S_HEADER;
          end else begin
            pay_load = 1'b1;
            if (remaining == 16'd1) begin
              frame_done = 1'b1;
              state_nxt  = S_IDLE;
            end
          end
        end
      end
      S_DISCARD: begin
        if (accept && sof) begin
          hdr_restart = 1'b1;
          state_nxt   = S_HEADER;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow     <= '0;
      index      <= 4'd0;
      hdr_q      <= '0;
      remaining  <= 16'd0;
      wait_count <= '0;
      tx_valid_q <= 1'b0;
      out_dat    <= 8'd0;
      out_vld    <= 1'b0;
      out_last   <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      if (hdr_restart) begin
        shadow[0] <= byte_in;
        index     <= 4'd1;
      end else if (hdr_wr) begin
        shadow[index] <= byte_in;
        index         <= index + 4'd1;
      end

      if (commit) begin
        hdr_q     <= hdr_in;
        remaining <= size_in;
      end else if (pay_load) begin
        remaining <= remaining - 16'd1;
      end

      if (commit) begin
        tx_valid_q <= 1'b1;
      end else if (grant || expire) begin
        tx_valid_q <= 1'b0;
      end

      if (state == S_REQUEST) begin
        wait_count <= wait_count + WAIT_W'(1);
      end else begin
        wait_count <= '0;
      end

      // Reload wins over drain so back-to-back bytes stream without a bubble.
      if (pay_load) begin
        out_dat  <= byte_in;
        out_vld  <= 1'b1;
        out_last <= (remaining == 16'd1);
      end else if (bus.udp_data_ready) begin
        out_vld  <= 1'b0;
        out_last <= 1'b0;
      end

      err_q      <= err_set;
      err_code_q <= err_set ? err_code_nxt : 3'd0;

      if (frame_done && frame_cnt != '1) begin
        frame_cnt <= frame_cnt + COUNTER_WIDTH'(1);
      end
      if (err_set && err_cnt != '1) begin
        err_cnt <= err_cnt + COUNTER_WIDTH'(1);
      end
    end
  end

  assign bus.mac_destination  = hdr_q.mac_destination;
  assign bus.ipv4_destination = hdr_q.ipv4_destination;
  assign bus.udp_destination  = hdr_q.udp_destination;
  assign bus.udp_source       = hdr_q.udp_source;
  assign bus.udp_data_size    = hdr_q.udp_data_size;
  assign bus.transmit_valid   = tx_valid_q;
  assign bus.udp_data         = out_dat;
  assign bus.udp_data_valid   = out_vld;
  assign bus.udp_data_last    = out_last;
  assign bus.frame_error      = err_q;
  assign bus.error_code       = err_code_q;
  assign bus.frame_count      = frame_cnt;
  assign bus.error_count      = err_cnt;

endmodule

// File: tb/tb_udp_transmit_framer.sv
// Bench for udp_transmit_framer: directed plus random frames, scoreboarded against a stream-level parse of the sent bytes.
// Grant delays are planned per request; a delay of GRANT_TIMEOUT or more means the grant never comes.
module tb_udp_transmit_framer;
  localparam int CW   = 16;
  localparam int GT   = 8;
  localparam int MAXS = 1472;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  udp_transmit_framer_if #(.COUNTER_WIDTH(CW)) bus ();

  udp_transmit_framer #(
    .MAX_UDP_DATA_SIZE(MAXS),
    .GRANT_TIMEOUT(GT),
    .COUNTER_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]   stim[$];
  int           gplan[$];
  logic [127:0] exp_hdr[$];
  logic [8:0]   exp_pay[$];
  logic [2:0]   exp_err[$];
  int           exp_vc[$];
  int           exp_frames = 0;
  int           exp_errs   = 0;
  int           ri         = 0;
  bit           mon_en     = 1'b0;
  bit           rdy_all    = 1'b0;
  bit           abort      = 1'b0;

  task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_header(input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] dp,
                             input logic [15:0] sp, input logic [15:0] size, input int d);
    logic [127:0] h;
    h = {mac, ip, dp, sp, size};
    for (int i = 0; i < 16; i++) stim.push_back({(i == 0), h[127-8*i -: 8]});
    if (size != 16'd0 && size <= 16'(MAXS)) gplan.push_back(d);
  endtask

  task automatic push_rand_header(input logic [15:0] size, input int d);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    push_header(r[47:0], $urandom(), 16'($urandom()), 16'($urandom()), size, d);
  endtask

  task automatic push_body(input int n);
    for (int i = 0; i < n; i++) stim.push_back({1'b0, 8'($urandom())});
  endtask

  task automatic push_partial(input int n);
    stim.push_back({1'b1, 8'($urandom())});
    push_body(n - 1);
  endtask

  // Expected behaviour derived from the byte stream alone: frames, errors, payload and request lengths.
  task automatic run_model();
    int mode, hi, rem, gi, d;
    logic [7:0]   h[16];
    logic [15:0]  sz;
    logic [127:0] hv;
    mode = 0; hi = 0; rem = 0; gi = 0;
    foreach (stim[n]) begin
      logic       s;
      logic [7:0] v;
      s = stim[n][8];
      v = stim[n][7:0];
      if (s) begin
        if (mode == 1) begin exp_err.push_back(3'd1); exp_errs++; end
        if (mode == 2) begin exp_err.push_back(3'd4); exp_errs++; end
        h[0] = v; hi = 1; mode = 1;
      end else if (mode == 1) begin
        h[hi] = v; hi++;
        if (hi == 16) begin
          sz = {h[14], h[15]};
          if (sz == 16'd0 || sz > 16'(MAXS)) begin
            exp_err.push_back(3'd2); exp_errs++; mode = 3;
          end else begin
            hv = '0;
            for (int i = 0; i < 16; i++) hv = {hv[119:0], h[i]};
            exp_hdr.push_back(hv);
            d = (gi < gplan.size()) ? gplan[gi] : 0;
            gi++;
            if (d >= GT) begin
              exp_vc.push_back(GT); exp_err.push_back(3'd3); exp_errs++; mode = 3;
            end else begin
              exp_vc.push_back(d + 1); rem = int'(sz); mode = 2;
            end
          end
        end
      end else if (mode == 2) begin
        exp_pay.push_back({(rem == 1), v});
        rem--;
        if (rem == 0) begin exp_frames++; mode = 0; end
      end
    end
  endtask

  task automatic send_byte(input logic [8:0] b);
    int guard;
    bit took;
    if (abort) return;
    if ($urandom_range(0, 3) == 0) begin
      bus.data_valid = 1'b0;
      repeat ($urandom_range(1, 2)) begin @(posedge clock); #1; end
    end
    bus.data       = b;
    bus.data_valid = 1'b1;
    guard = 0;
    took  = 1'b0;
    while (!took) begin
      @(negedge clock);
      took = bus.data_ready;
      @(posedge clock); #1;
      if (!took) begin
        guard++;
        if (guard > 300) begin
          check_eq("accept_timeout", 136'(guard), 136'(0));
          abort = 1'b1;
          return;
        end
      end
    end
  endtask

  task automatic check_all_zero(input string phase);
    check_eq({phase, "_data_ready"}, 136'(bus.data_ready), 136'(0));
    check_eq({phase, "_tx_valid"}, 136'(bus.transmit_valid), 136'(0));
    check_eq({phase, "_udp_valid"}, 136'(bus.udp_data_valid), 136'(0));
    check_eq({phase, "_udp_last"}, 136'(bus.udp_data_last), 136'(0));
    check_eq({phase, "_udp_data"}, 136'(bus.udp_data), 136'(0));
    check_eq({phase, "_frame_error"}, 136'({bus.frame_error, bus.error_code}), 136'(0));
    check_eq({phase, "_fields"}, 136'({bus.mac_destination, bus.ipv4_destination, bus.udp_destination,
                                       bus.udp_source, bus.udp_data_size}), 136'(0));
    check_eq({phase, "_frame_count"}, 136'(bus.frame_count), 136'(0));
    check_eq({phase, "_error_count"}, 136'(bus.error_count), 136'(0));
  endtask

  // Transmit responder: grants after the planned delay and measures how long transmit_valid stays up.
  initial begin
    int  k, d;
    bit  in_req;
    k = 0; d = 0; in_req = 1'b0;
    bus.transmit_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (!mon_en) begin
        bus.transmit_ready = 1'b1;
      end else if (bus.transmit_valid) begin
        if (!in_req) begin
          in_req = 1'b1;
          k = 0;
          d = (ri < gplan.size()) ? gplan[ri] : 0;
          ri++;
          check_eq("hdr_fields",
                   {8'h00, bus.mac_destination, bus.ipv4_destination, bus.udp_destination,
                    bus.udp_source, bus.udp_data_size},
                   (exp_hdr.size() != 0) ? {8'h00, exp_hdr.pop_front()} : {8'hFF, 128'h0});
        end else begin
          k++;
        end
        bus.transmit_ready = (k == d);
      end else begin
        if (in_req) begin
          in_req = 1'b0;
          check_eq("tx_valid_cycles", 136'(k + 1), (exp_vc.size() != 0) ? 136'(exp_vc.pop_front()) : 136'(0));
        end
        bus.transmit_ready = ($urandom_range(0, 1) == 1);
      end
    end
  end

  initial begin
    bus.udp_data_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      bus.udp_data_ready = rdy_all || ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clock) begin
    if (mon_en && bus.udp_data_valid && bus.udp_data_ready)
      check_eq("payload", 136'({1'b0, bus.udp_data_last, bus.udp_data}),
               (exp_pay.size() != 0) ? 136'({1'b0, exp_pay.pop_front()}) : 136'(10'h3FF));
    if (mon_en && bus.frame_error)
      check_eq("error_code", 136'({1'b0, bus.error_code}),
               (exp_err.size() != 0) ? 136'({1'b0, exp_err.pop_front()}) : 136'(4'hF));
  end

  initial begin
    logic [127:0] rh;
    int           kind, sz;
    bus.data       = 9'd0;
    bus.data_valid = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clock); #1;
    check_eq("idle_data_ready", 136'(bus.data_ready), 136'(1));

    push_header(48'h020000000001, 32'hC0A80002, 16'h1234, 16'h5678, 16'h0003, 2);
    stim.push_back(9'h0AA); stim.push_back(9'h0BB); stim.push_back(9'h0CC);
    push_partial(7);
    push_rand_header(16'd2, 0); push_body(2);
    push_rand_header(16'd0, 0); push_body(4);
    push_rand_header(16'd1473, 0); push_body(3);
    push_rand_header(16'd4, 20); push_body(4);
    push_rand_header(16'd2, 7); push_body(2);
    push_rand_header(16'd5, 1); push_body(2);
    push_rand_header(16'd1, 0); push_body(1);
    push_rand_header(16'd1472, 0); push_body(1472);
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      sz   = $urandom_range(1, 6);
      if (kind <= 5) begin
        push_rand_header(16'(sz), $urandom_range(0, 9)); push_body(sz);
      end else if (kind == 6) begin
        push_rand_header(16'(sz), $urandom_range(0, 3)); push_body($urandom_range(0, sz - 1));
      end else if (kind == 7) begin
        push_partial($urandom_range(1, 15));
        continue;
      end else if (kind == 8) begin
        push_rand_header(($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(MAXS + 1, 65535)), 0);
      end else begin
        push_rand_header(16'd2, $urandom_range(GT, GT + 4)); push_body(2);
      end
      push_body($urandom_range(0, 2));
    end
    push_rand_header(16'd3, 1); push_body(3);

    run_model();
    mon_en = 1'b1;
    foreach (stim[i]) send_byte(stim[i]);
    bus.data_valid = 1'b0;
    rdy_all = 1'b1;

    for (int c = 0; c < 3000 && (exp_pay.size() + exp_hdr.size() + exp_err.size() + exp_vc.size()) != 0; c++)
      @(posedge clock);
    repeat (5) @(posedge clock);
    #1;
    check_eq("payload_left", 136'(exp_pay.size()), 136'(0));
    check_eq("hdr_left", 136'(exp_hdr.size()), 136'(0));
    check_eq("errors_left", 136'(exp_err.size()), 136'(0));
    check_eq("requests_left", 136'(exp_vc.size()), 136'(0));
    check_eq("frame_count", 136'(bus.frame_count), 136'(exp_frames));
    check_eq("error_count", 136'(bus.error_count), 136'(exp_errs));

    // Abandon a frame mid-payload with reset.
    mon_en = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rh = {48'h0A0B0C0D0E0F, 32'h01020304, 16'h1111, 16'h2222, 16'h0005};
    for (int i = 0; i < 16; i++) send_byte({(i == 0), rh[127-8*i -: 8]});
    send_byte(9'h011);
    send_byte(9'h022);
    bus.data_valid = 1'b0;
    check_eq("pre_reset_fields", 136'({bus.mac_destination, bus.ipv4_destination, bus.udp_destination,
                                       bus.udp_source, bus.udp_data_size}), 136'(rh));
    reset = 1'b1;
    @(posedge clock); #1;
    check_all_zero("midreset");
    reset = 1'b0;
    @(posedge clock); #1;
    check_eq("post_reset_data_ready", 136'(bus.data_ready), 136'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
